unsadd_frame_sched: RTL

UNSADD_FRAME_SCHED -- requirements
Module: unsadd_frame_sched

---
 rtl/unsadd_frame_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/unsadd_frame_sched.sv
// Round-robin scheduler time-sharing one uNSADD unary adder among NREQ requesters.
// Each grant runs one CLEAR/RUN/DONE frame and reports the ones count seen on iC.
//
// Handshake: a requester raises iReq[i] and keeps it high until it sees oGnt[i].
// iReq is only sampled while the scheduler is idle. Once a grant is taken it
// cannot be revoked: the frame always runs to its oDone pulse, even if the
// request drops. The only exception is iRst, which aborts the frame.
module unsadd_frame_sched #(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 256,
    parameter int CNTW      = 9
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic [NREQ-1:0]         iReq,
    input  logic [NREQ-1:0]         iA,
    input  logic [NREQ-1:0]         iB,
    input  logic                    iC,
    output logic [NREQ-1:0]         oGnt,
    output logic                    oAddRstN,
    output logic                    oA,
    output logic                    oB,
    output logic                    oDone,
    output logic [$clog2(NREQ)-1:0] oDoneId,
    output logic [CNTW-1:0]         oCount,
    output logic                    oBusy,
    output logic [1:0]              oState
);

    localparam int IDW = $clog2(NREQ);
    localparam int FCW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  gidx_q, gidx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [FCW-1:0]  frame_q, frame_d;
    logic [CNTW-1:0] ones_q, ones_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic [IDW-1:0]  idx_v;
    logic [CNTW-1:0] ones_run;
    logic [IDW-1:0]  ptr_next;
    logic            frame_last;

    // Scan downward so the lowest offset from the pointer is the last write.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        idx_v      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_v = IDW'((int'(ptr_q) + k) % NREQ);
            if (iReq[idx_v]) begin
                pick_found = 1'b1;
                pick_idx   = idx_v;
            end
        end
    end

    always_comb begin
        ones_run = ones_q;
        if (iC && (ones_q != CNTW'(FRAME_LEN))) begin
            ones_run = ones_q + 1'b1;
        end
    end

    assign ptr_next   = (gidx_q == IDW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
    assign frame_last = (frame_q == FCW'(FRAME_LEN - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        frame_d = frame_q;
        ones_d  = ones_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gidx_d           = pick_idx;
                    gnt_d            = '0;
                    gnt_d[pick_idx]  = 1'b1;
                    state_d          = S_CLEAR;
                end
            end
            S_CLEAR: begin
                ones_d  = '0;
                frame_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                ones_d  = ones_run;
                frame_d = frame_q + 1'b1;
                // Capture the result including the final RUN cycle's iC.
                if (frame_last) begin
                    frame_d = '0;
                    id_d    = gidx_q;
                    cnt_d   = ones_run;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ptr_d   = ptr_next;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            gnt_q   <= '0;
            frame_q <= '0;
            ones_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            frame_q <= frame_d;
            ones_q  <= ones_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oGnt     = gnt_q;
    assign oAddRstN = (state_q == S_RUN) || (state_q == S_DONE);
    assign oA       = (state_q == S_RUN) ? iA[gidx_q] : 1'b0;
    assign oB       = (state_q == S_RUN) ? iB[gidx_q] : 1'b0;
    assign oDone    = (state_q == S_DONE);
    assign oDoneId  = id_q;
    assign oCount   = cnt_q;
    assign oBusy    = (state_q != S_IDLE);
    assign oState   = state_q;

endmodule
